// File: rtl/mmx_multimode_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmx_counter_pkg
// Brief    : Shared types and constants for the multimode counter.
// Revision : 1.0 - initial release
// ============================================================================
package mmx_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mmx_multimode_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : mmx_multimode_counter_if
// Brief    : Control and status bundle between the pin wrapper and counter.
// Revision : 1.0 - initial release
// ============================================================================
interface mmx_multimode_counter_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] div;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;

  // Controller side: drives configuration, observes counter state.
  modport master (
    output en, mode, sat, load, load_val, limit, div,
    input  count, dir, tc
  );

  // Counter side.
  modport slave (
    input  en, mode, sat, load, load_val, limit, div,
    output count, dir, tc
  );
endinterface
`default_nettype wire

// File: rtl/mmx_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : mmx_prescaler
// Brief    : Enable-gated divider; one tick every (div+1) enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mmx_prescaler #(
  parameter int PRE_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic             clr,
  input  wire logic [PRE_W-1:0] div,
  output logic                  tick
);

  logic [PRE_W-1:0] r_pcnt;

  // Compared live against div so a new divisor applies at the next compare.
  assign tick = en && (r_pcnt == div);

  // Phase counter: cleared by load or tick, frozen while en is low, and
  // free-wrapping if it finds itself above a newly lowered divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (clr || tick) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmx_multimode_counter.sv
`default_nettype none
// ============================================================================
// Module   : mmx_multimode_counter
// Brief    : WIDTH-bit up/down/bounce/hold counter with prescaler, top limit,
//            wrap/saturate, synchronous load and registered terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module mmx_multimode_counter
  import mmx_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mmx_multimode_counter_if.slave bus
);

  logic             w_tick;
  mode_t            w_mode;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_dir_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_top_less1;

  assign w_mode = mode_t'(bus.mode);

  // Bounce turnaround target at the top; degenerates to 0 when limit is 0.
  assign w_top_less1 = (bus.limit == '0) ? '0 : bus.limit - 1'b1;

  mmx_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .div  (bus.div),
    .tick (w_tick)
  );

  // Next-state: load beats tick; count >= limit is treated as the top edge.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_tc_nxt    = 1'b0;
    if (bus.load) begin
      w_count_nxt = bus.load_val;
      if (w_mode == MODE_BOUNCE) begin
        w_dir_nxt = DIR_UP;
      end
    end else if (w_tick) begin
      case (w_mode)
        MODE_UP: begin
          w_dir_nxt = DIR_UP;
          if (r_count < bus.limit) begin
            w_count_nxt = r_count + 1'b1;
          end else begin
            w_count_nxt = bus.sat ? bus.limit : '0;
            w_tc_nxt    = 1'b1;
          end
        end
        MODE_DOWN: begin
          w_dir_nxt = DIR_DOWN;
          if (r_count != '0) begin
            w_count_nxt = r_count - 1'b1;
          end else begin
            w_count_nxt = bus.sat ? '0 : bus.limit;
            w_tc_nxt    = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (r_count < bus.limit) begin
              w_count_nxt = r_count + 1'b1;
            end else begin
              w_dir_nxt   = DIR_DOWN;
              w_count_nxt = w_top_less1;
              w_tc_nxt    = 1'b1;
            end
          end else begin
            if (r_count != '0) begin
              w_count_nxt = r_count - 1'b1;
            end else begin
              w_dir_nxt   = DIR_UP;
              w_count_nxt = (bus.limit == '0) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
              w_tc_nxt    = 1'b1;
            end
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // State registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.dir   = r_dir;
  assign bus.tc    = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_mmx_multimode_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmx_multimode_counter
// Brief    : Directed self-checking bench for mmx_multimode_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmx_multimode_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mmx_multimode_counter_if #(.WIDTH(8), .PRE_W(4)) bus ();

  mmx_multimode_counter #(
    .WIDTH (8),
    .PRE_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load_val = v;
    bus.load     = 1'b1;
    step(1);
    bus.load     = 1'b0;
  endtask

  int bc_cnt [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  int bc_dir [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  int bc_tc  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 2'd0;
    bus.sat      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
    bus.limit    = 8'd5;
    bus.div      = 4'd0;
    step(2);
    check("rst_count", bus.count, 0);
    check("rst_dir",   bus.dir,   0);
    check("rst_tc",    bus.tc,    0);

    // Basic up count, limit 5, wrap.
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("up_count", bus.count, (i == 5) ? 0 : ((i == 6) ? 1 : i + 1));
      check("up_tc",    bus.tc,    (i == 5) ? 1 : 0);
    end

    // Prescaler div=2 with an en gap mid-period.
    bus.div = 4'd2;
    do_load(8'd0);
    check("load_tc", bus.tc, 0);
    step(2);
    check("pre_hold0", bus.count, 0);
    step(1);
    check("pre_tick1", bus.count, 1);
    step(1);
    bus.en = 1'b0;
    step(4);
    check("pre_frozen", bus.count, 1);
    bus.en = 1'b1;
    step(1);
    check("pre_resume", bus.count, 1);
    step(1);
    check("pre_tick2", bus.count, 2);

    // Down with saturate from 2.
    bus.div  = 4'd0;
    bus.mode = 2'd1;
    bus.sat  = 1'b1;
    do_load(8'd2);
    check("dn_load", bus.count, 2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("dn_count", bus.count, (i == 0) ? 1 : 0);
      check("dn_tc",    bus.tc,    (i >= 2) ? 1 : 0);
      check("dn_dir",   bus.dir,   1);
    end

    // Bounce, limit 3.
    bus.mode  = 2'd2;
    bus.sat   = 1'b0;
    bus.limit = 8'd3;
    do_load(8'd0);
    check("bc_load_dir", bus.dir, 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("bc_count", bus.count, bc_cnt[i]);
      check("bc_dir",   bus.dir,   bc_dir[i]);
      check("bc_tc",    bus.tc,    bc_tc[i]);
    end

    // Hold: count frozen, no tc.
    bus.mode = 2'd3;
    step(3);
    check("hold_count", bus.count, 2);
    check("hold_tc",    bus.tc,    0);

    // Load above limit in up/wrap mode.
    bus.mode  = 2'd0;
    bus.limit = 8'd10;
    do_load(8'd200);
    check("over_load", bus.count, 200);
    step(1);
    check("over_count", bus.count, 0);
    check("over_tc",    bus.tc,    1);

    // limit 0: pinned at 0, tc every tick, up and bounce.
    bus.limit = 8'd0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("lim0_up_count", bus.count, 0);
      check("lim0_up_tc",    bus.tc,    1);
    end
    bus.mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("lim0_bc_count", bus.count, 0);
      check("lim0_bc_tc",    bus.tc,    1);
      check("lim0_bc_dir",   bus.dir,   (i == 0) ? 1 : 0);
    end

    // Load coincident with a tick: load wins.
    bus.mode  = 2'd0;
    bus.limit = 8'd20;
    do_load(8'd7);
    check("ld_tick_count", bus.count, 7);
    check("ld_tick_tc",    bus.tc,    0);
    step(1);
    check("ld_tick_next", bus.count, 8);

    // Async reset between edges, then restart after div+1 cycles.
    bus.div = 4'd2;
    do_load(8'd5);
    step(3);
    check("ar_pre", bus.count, 6);
    step(1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_count", bus.count, 0);
    check("ar_dir",   bus.dir,   0);
    step(1);
    rst = 1'b0;
    step(2);
    check("ar_wait", bus.count, 0);
    step(1);
    check("ar_first", bus.count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
